// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v counters, arm-on-full streaming FSM and a
// two-stage output pipeline that turns FIFO pixels into RGB/HS/VS/BLANK at the pins.
module vga_sync_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic [23:0] fifo_rdata,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_read,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic        VGA_SYNC,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_start,
  output logic        underflow
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_B = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT_B  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_B = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT_B  = VW'(VFP + VPULSE + VBP);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t         state, state_n;
  logic [HW-1:0]  hcnt;
  logic [VW-1:0]  vcnt;
  logic           h_sync, v_sync, active_px, frame_origin;

  // stage-1 registers
  logic s1_hs, s1_vs, s1_blank, s1_rd, s1_bad, s1_fs;

  assign h_sync       = (hcnt >= H_SYNC_B) && (hcnt < H_SYNC_E);
  assign v_sync       = (vcnt >= V_SYNC_B) && (vcnt < V_SYNC_E);
  assign active_px    = (hcnt >= H_ACT_B) && (vcnt >= V_ACT_B);
  assign frame_origin = (hcnt == '0) && (vcnt == '0);
  assign fifo_read    = (state == RUN) && active_px;
  assign VGA_SYNC     = 1'b0;

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) state <= IDLE;
    else       state <= state_n;
  end

  // Streaming only ever starts at the frame origin, so a frame is never partially drawn.
  always_comb begin
    // NOTE: default assigned first so every path drives state_n and no latch is inferred.
    state_n = state;
    unique case (state)
      IDLE:    if (fifo_full)    state_n = ARMED;
      ARMED:   if (frame_origin) state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the pixel datapath is reset too, because black pins out of reset are part of the contract.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_blank <= 1'b0;
      s1_rd    <= 1'b0;
      s1_bad   <= 1'b0;
      s1_fs    <= 1'b0;
    end else begin
      s1_hs    <= ~h_sync;
      s1_vs    <= ~v_sync;
      s1_blank <= active_px;
      s1_rd    <= fifo_read;
      s1_bad   <= fifo_read & fifo_empty;
      s1_fs    <= frame_origin;
    end
  end

  // Stage 2: FIFO data arrives the cycle after the read, i.e. alongside s1_rd.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      VGA_HS                <= 1'b1;
      VGA_VS                <= 1'b1;
      VGA_BLANK             <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
      frame_start           <= 1'b0;
      underflow             <= 1'b0;
    end else begin
      VGA_HS                <= s1_hs;
      VGA_VS                <= s1_vs;
      VGA_BLANK             <= s1_blank;
      {VGA_R, VGA_G, VGA_B} <= (s1_rd && !s1_bad) ? fifo_rdata : 24'h0;
      frame_start           <= s1_fs;
      // Flag rises with the zeroed pixel; a coincident set beats the frame clear.
      if (s1_bad)     underflow <= 1'b1;
      else if (s1_fs) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: small-geometry timing table, arming, data path,
// underflow, mid-frame reset, plus an HS period check on a default-size instance.
module tb_vga_sync_gen;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [23:0] fifo_rdata = 24'h0;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_read;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        frame_start, underflow;

  logic        b_read, b_hs, b_vs, b_blank, b_sync, b_fs, b_uf;
  logic [7:0]  b_r, b_g, b_b;

  always #5 CLK = ~CLK;

  // Small geometry: HTOTAL=8 (fp 0, sync 1..2, bp 3, active 4..7), VTOTAL=6 (sync 1, active 3..5).
  vga_sync_gen #(
    .HDISP(4), .VDISP(3), .HFP(1), .HPULSE(2), .HBP(1),
    .VFP(1), .VPULSE(1), .VBP(1)
  ) dut (
    .CLK(CLK), .NRST(NRST), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_read(fifo_read), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .frame_start(frame_start), .underflow(underflow)
  );

  vga_sync_gen dut_big (
    .CLK(CLK), .NRST(NRST), .fifo_rdata(24'h0), .fifo_empty(1'b0),
    .fifo_full(1'b0), .fifo_read(b_read), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK(b_blank), .VGA_SYNC(b_sync), .VGA_R(b_r), .VGA_G(b_g),
    .VGA_B(b_b), .frame_start(b_fs), .underflow(b_uf)
  );

  // FIFO model: pops an incrementing pattern; can report empty on the 5th read of a frame.
  logic [23:0] next_val = 24'h1;
  int          rd_cnt = 0;
  logic        empty_mode;

  assign fifo_empty = empty_mode && (rd_cnt == 4);

  always @(posedge CLK) begin
    if (!NRST) rd_cnt <= 0;
    else if (fifo_read) begin
      fifo_rdata <= next_val;
      next_val   <= next_val + 24'h1;
      rd_cnt     <= (rd_cnt == 11) ? 0 : rd_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-frame capture, index = clocks since the frame_start pulse at the pins.
  logic        hs_a [48];
  logic        vs_a [48];
  logic        bl_a [48];
  logic        rd_a [48];
  logic        uf_a [48];
  logic        fs_a [48];
  logic [23:0] rgb_a[48];

  task automatic capture();
    for (int t = 0; t < 48; t++) begin
      if (t > 0) @(negedge CLK);
      hs_a[t]  = VGA_HS;
      vs_a[t]  = VGA_VS;
      bl_a[t]  = VGA_BLANK;
      rd_a[t]  = fifo_read;
      uf_a[t]  = underflow;
      fs_a[t]  = frame_start;
      rgb_a[t] = {VGA_R, VGA_G, VGA_B};
    end
  endtask

  task automatic next_frame(input string name);
    @(negedge CLK);
    check(name, frame_start, 1'b1);
  endtask

  task automatic wait_fs(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      @(negedge CLK);
      seen = frame_start;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"},    VGA_HS, 1'b1);
    check({tag, "_vs"},    VGA_VS, 1'b1);
    check({tag, "_blank"}, VGA_BLANK, 1'b0);
    check({tag, "_rgb"},   {VGA_R, VGA_G, VGA_B}, 24'h0);
    check({tag, "_fs"},    frame_start, 1'b0);
    check({tag, "_uf"},    underflow, 1'b0);
    check({tag, "_read"},  fifo_read, 1'b0);
    check({tag, "_sync"},  VGA_SYNC, 1'b0);
  endtask

  task automatic check_no_stream(input string tag);
    int reads = 0, lit = 0;
    for (int t = 0; t < 48; t++) begin
      if (rd_a[t]) reads++;
      if (rgb_a[t] != 24'h0) lit++;
    end
    check({tag, "_reads"}, reads, 0);
    check({tag, "_rgb_nonzero"}, lit, 0);
  endtask

  task automatic check_pixels(input string tag, input logic [23:0] base, input int bad_k);
    int k = 0, outside = 0;
    for (int t = 0; t < 48; t++) begin
      if (bl_a[t]) begin
        check($sformatf("%s_px%0d", tag, k), rgb_a[t], (k == bad_k) ? 32'h0 : base + k);
        k++;
      end else if (rgb_a[t] != 24'h0) outside++;
    end
    check({tag, "_pixel_count"}, k, 12);
    check({tag, "_rgb_outside_blank"}, outside, 0);
  endtask

  typedef struct {
    int   t;
    logic hs;
    logic vs;
    logic bl;
  } tvec_t;

  tvec_t tv[14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs_low, vs_low, bl_hi, fs_cnt, first_rd, reads, uf_cnt;

    tv = '{'{0, 1, 1, 0}, '{1, 0, 1, 0}, '{2, 0, 1, 0}, '{3, 1, 1, 0},
           '{7, 1, 1, 0}, '{8, 1, 0, 0}, '{9, 0, 0, 0}, '{15, 1, 0, 0},
           '{16, 1, 1, 0}, '{27, 1, 1, 0}, '{28, 1, 1, 1}, '{31, 1, 1, 1},
           '{33, 0, 1, 0}, '{47, 1, 1, 1}};

    NRST = 1'b0; fifo_full = 1'b0; empty_mode = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");

    NRST = 1'b1;
    @(negedge CLK) check("fs_one_after_release", frame_start, 1'b0);
    @(negedge CLK) check("fs_two_after_release", frame_start, 1'b1);

    // Frame 0: timing table and per-frame totals, no streaming yet.
    capture();
    foreach (tv[i]) begin
      check($sformatf("hs_t%0d", tv[i].t), hs_a[tv[i].t], tv[i].hs);
      check($sformatf("vs_t%0d", tv[i].t), vs_a[tv[i].t], tv[i].vs);
      check($sformatf("blank_t%0d", tv[i].t), bl_a[tv[i].t], tv[i].bl);
    end
    hs_low = 0; vs_low = 0; bl_hi = 0; fs_cnt = 0;
    for (int t = 0; t < 48; t++) begin
      if (!hs_a[t]) hs_low++;
      if (!vs_a[t]) vs_low++;
      if (bl_a[t])  bl_hi++;
      if (fs_a[t])  fs_cnt++;
    end
    check("hs_low_per_frame", hs_low, 12);
    check("vs_low_per_frame", vs_low, 8);
    check("blank_high_per_frame", bl_hi, 12);
    check("fs_pulses_per_frame", fs_cnt, 1);
    check_no_stream("idle_f0");

    next_frame("fs_period_f1");
    capture();
    check_no_stream("idle_f1");

    // Frame 2: full pulse mid-frame must not start streaming in this frame.
    next_frame("fs_period_f2");
    reads = 0;
    for (int t = 1; t < 48; t++) begin
      @(negedge CLK);
      if (t == 20) fifo_full = 1'b1;
      if (t == 21) fifo_full = 1'b0;
      if (fifo_read) reads++;
    end
    check("armed_f2_reads", reads, 0);

    // Frame 3: first streamed frame.
    next_frame("fs_period_f3");
    capture();
    first_rd = -1;
    reads = 0;
    for (int t = 0; t < 48; t++) begin
      if (rd_a[t]) begin
        reads++;
        if (first_rd < 0) first_rd = t;
      end
    end
    check("run_first_read_index", first_rd, 26);
    check("run_reads_per_frame", reads, 12);
    check_pixels("f3", 24'd1, -1);
    check("f3_underflow", uf_a[47], 1'b0);

    // Frame 4: FIFO empty on the 5th read.
    empty_mode = 1'b1;
    next_frame("fs_period_f4");
    capture();
    empty_mode = 1'b0;
    check_pixels("f4", 24'd13, 4);
    check("uf_before_bad_px", uf_a[35], 1'b0);
    check("uf_at_bad_px", uf_a[36], 1'b1);
    check("uf_sticky_eof", uf_a[47], 1'b1);

    next_frame("fs_period_f5");
    check("uf_cleared_at_fs", underflow, 1'b0);
    capture();
    uf_cnt = 0;
    for (int t = 0; t < 48; t++) if (uf_a[t]) uf_cnt++;
    check("uf_stays_clear_f5", uf_cnt, 0);
    check_pixels("f5", 24'd25, -1);

    // Reset for one cycle while the counters sit at hcnt=5, vcnt=2 (pin time 19).
    next_frame("fs_period_f6");
    repeat (19) @(negedge CLK);
    NRST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midreset");
    NRST = 1'b1;
    @(negedge CLK) check("midreset_fs_minus1", frame_start, 1'b0);
    @(negedge CLK) check("midreset_fs", frame_start, 1'b1);
    reads = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (fifo_read) reads++;
    end
    check("midreset_idle_reads", reads, 0);

    fifo_full = 1'b1;
    @(negedge CLK);
    fifo_full = 1'b0;
    wait_fs("rearm_fs_seen");
    reads = 0;
    for (int t = 0; t < 48; t++) begin
      if (fifo_read) reads++;
      @(negedge CLK);
    end
    check("rearm_reads_per_frame", reads, 12);

    // Default geometry: HS falling edges are HTOTAL = 928 clocks apart.
    begin
      logic prev;
      bit   f0, f1;
      int   n;
      f0 = 1'b0; f1 = 1'b0; n = 0;
      prev = b_hs;
      for (int i = 0; i < 2000 && !f0; i++) begin
        @(negedge CLK);
        if (prev && !b_hs) f0 = 1'b1;
        prev = b_hs;
      end
      for (int i = 0; i < 2000 && !f1; i++) begin
        @(negedge CLK);
        n++;
        if (prev && !b_hs) f1 = 1'b1;
        prev = b_hs;
      end
      check("big_hs_edges_found", {f0, f1}, 2'b11);
      check("big_hs_period", n, 928);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
